// File: rtl/overlay_ctrl_if.sv
// overlay_ctrl_if: host streams, job control and overlay-side signals.
// master drives job/host inputs; slave is the controller.
interface overlay_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int INST_WIDTH = 32
) ();
  logic                    start;
  logic [7:0]              cfg_inst_num;
  logic                    s_inst_v;
  logic [INST_WIDTH-1:0]   s_inst;
  logic                    s_inst_rdy;
  logic                    s_data_v;
  logic [2*DATA_WIDTH-1:0] s_data;
  logic                    s_data_rdy;
  logic                    ce;
  logic                    inst_in_v;
  logic [INST_WIDTH-1:0]   inst_in;
  logic                    din_overlay_v;
  logic [2*DATA_WIDTH-1:0] din_overlay;
  logic                    alpha_v;
  logic                    load;
  logic                    dout_overlay_v;
  logic                    busy;
  logic                    done;
  logic                    err;

  modport master (
    output start, cfg_inst_num,
    output s_inst_v, s_inst,
    output s_data_v, s_data,
    output dout_overlay_v,
    input  s_inst_rdy, s_data_rdy,
    input  ce, inst_in_v, inst_in,
    input  din_overlay_v, din_overlay,
    input  alpha_v, load,
    input  busy, done, err
  );

  modport slave (
    input  start, cfg_inst_num,
    input  s_inst_v, s_inst,
    input  s_data_v, s_data,
    input  dout_overlay_v,
    output s_inst_rdy, s_data_rdy,
    output ce, inst_in_v, inst_in,
    output din_overlay_v, din_overlay,
    output alpha_v, load,
    output busy, done, err
  );
endinterface

// File: rtl/overlay_ctrl.sv
// overlay_ctrl: one-job-at-a-time sequencer, inst -> data -> compute -> drain.
// Optional DRAIN watchdog: define OVERLAY_CTRL_WATCHDOG_EN.
module overlay_ctrl #(
  parameter int PE_NUM      = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int INST_WIDTH  = 32,
  parameter int COMPUTE_LAT = 12,
  parameter int TIMEOUT     = 255
) (
  input logic          clk,
  input logic          rst,
  overlay_ctrl_if.slave bus
);
  localparam int DW   = 2 * DATA_WIDTH;
  localparam int IC_W = 8;
  localparam int DC_W = $clog2(PE_NUM + 1);
  localparam int CC_W = $clog2(COMPUTE_LAT + 1);

  if (COMPUTE_LAT < 1 || TIMEOUT < 1 || PE_NUM < 1) begin : g_bad_cfg
    $error("overlay_ctrl: COMPUTE_LAT, TIMEOUT, PE_NUM must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE, INST, DATA, COMP, DRAIN, DONE
  } state_e;

  state_e          state_q;
  logic [IC_W-1:0] inst_num_q;
  logic [IC_W-1:0] ic_q;
  logic [DC_W-1:0] dc_q;
  logic [CC_W-1:0] cc_q;
  logic [DC_W-1:0] oc_q;
  logic [INST_WIDTH-1:0] inst_q;
  logic            inst_v_q;
  logic [DW-1:0]   din_q;
  logic            din_v_q;
  logic            alpha_q;
  logic            load_q;
  logic            done_q;

  logic inst_rdy, data_rdy;
  logic inst_hs, data_hs;
  logic inst_last, data_last;
  logic comp_last, drain_last;

  assign inst_rdy   = (state_q == INST);
  assign data_rdy   = (state_q == DATA);
  assign inst_hs    = bus.s_inst_v && inst_rdy;
  assign data_hs    = bus.s_data_v && data_rdy;
  assign inst_last  = (ic_q == inst_num_q - 8'd1);
  assign data_last  = (dc_q == DC_W'(PE_NUM - 1));
  assign comp_last  = (cc_q == CC_W'(COMPUTE_LAT - 1));
  assign drain_last = (oc_q == DC_W'(PE_NUM - 1));

`ifdef OVERLAY_CTRL_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q;
  logic            err_q;
  logic            wd_hit;
  assign wd_hit = (wd_q == WD_W'(TIMEOUT - 1));
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      inst_num_q <= '0;
      ic_q       <= '0;
      dc_q       <= '0;
      cc_q       <= '0;
      oc_q       <= '0;
      inst_q     <= '0;
      inst_v_q   <= 1'b0;
      din_q      <= '0;
      din_v_q    <= 1'b0;
      alpha_q    <= 1'b0;
      load_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef OVERLAY_CTRL_WATCHDOG_EN
      wd_q       <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      inst_v_q <= 1'b0;
      din_v_q  <= 1'b0;
      alpha_q  <= 1'b0;
      load_q   <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            inst_num_q <= bus.cfg_inst_num;
`ifdef OVERLAY_CTRL_WATCHDOG_EN
            err_q      <= 1'b0;
`endif
            if (bus.cfg_inst_num == '0) begin
              state_q <= DATA;
            end else begin
              state_q <= INST;
            end
          end
        end
        INST: begin
          if (inst_hs) begin
            inst_q   <= bus.s_inst;
            inst_v_q <= 1'b1;
            if (inst_last) begin
              ic_q    <= '0;
              state_q <= DATA;
            end else begin
              ic_q <= ic_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (data_hs) begin
            din_q   <= bus.s_data;
            din_v_q <= 1'b1;
            if (data_last) begin
              dc_q    <= '0;
              alpha_q <= 1'b1;
              state_q <= COMP;
            end else begin
              dc_q <= dc_q + 1'b1;
            end
          end
        end
        COMP: begin
          if (comp_last) begin
            cc_q    <= '0;
            load_q  <= 1'b1;
            state_q <= DRAIN;
          end else begin
            cc_q <= cc_q + 1'b1;
          end
        end
        DRAIN: begin
          if (bus.dout_overlay_v) begin
`ifdef OVERLAY_CTRL_WATCHDOG_EN
            wd_q <= '0;
`endif
            if (drain_last) begin
              oc_q    <= '0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              oc_q <= oc_q + 1'b1;
            end
          end
`ifdef OVERLAY_CTRL_WATCHDOG_EN
          // Silent overlay: give up, still close the job with done.
          else if (wd_hit) begin
            wd_q    <= '0;
            oc_q    <= '0;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
`endif
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.s_inst_rdy    = inst_rdy;
  assign bus.s_data_rdy    = data_rdy;
  assign bus.busy          = (state_q != IDLE);
  // COMP follows the last data beat, so ce covers its registered word.
  assign bus.ce            = (state_q != IDLE);
  assign bus.inst_in_v     = inst_v_q;
  assign bus.inst_in       = inst_q;
  assign bus.din_overlay_v = din_v_q;
  assign bus.din_overlay   = din_q;
  assign bus.alpha_v       = alpha_q;
  assign bus.load          = load_q;
  assign bus.done          = done_q;
`ifdef OVERLAY_CTRL_WATCHDOG_EN
  assign bus.err           = err_q;
`else
  assign bus.err           = 1'b0;
`endif
endmodule

// File: doc/overlay_ctrl.md
Name: overlay_ctrl

Overview:
- Sequencer for the PE overlay; sits between the host stream interfaces and the overlay top.
- Runs one job at a time:
  - broadcasts a configurable number of instructions to all PEs;
  - streams PE_NUM input words into the input SIPO;
  - fires alpha_v and waits a fixed compute latency;
  - pulses load into the output PISO;
  - counts PE_NUM output words, then reports done.

Parameters:
- PE_NUM, 8, number of PEs / words per input and output frame
- DATA_WIDTH, 16, component width; data words are 2*DATA_WIDTH (I/Q)
- INST_WIDTH, 32, instruction word width
- COMPUTE_LAT, 12, cycles from alpha_v pulse to load pulse (>=1)
- TIMEOUT, 255, watchdog limit in DRAIN (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- start  in  1  job request; sampled in IDLE only
- cfg_inst_num  in  8  instructions in this job; latched on accepted start
- s_inst_v  in  1  host instruction valid
- s_inst  in  INST_WIDTH  host instruction
- s_inst_rdy  out  1  instruction accepted when s_inst_v & s_inst_rdy
- s_data_v  in  1  host data valid
- s_data  in  2*DATA_WIDTH  host data
- s_data_rdy  out  1  data accepted when s_data_v & s_data_rdy
- ce  out  1  overlay clock enable
- inst_in_v  out  1  instruction valid to overlay
- inst_in  out  INST_WIDTH  instruction to overlay
- din_overlay_v  out  1  data valid to overlay
- din_overlay  out  2*DATA_WIDTH  data to overlay
- alpha_v  out  1  compute trigger pulse
- load  out  1  PISO load pulse
- dout_overlay_v  in  1  overlay output-word valid
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job end
- err  out  1  watchdog error (optional feature only; otherwise tied 0)

Behaviour:
- Reset (rst=0 at a clk edge):
  - state goes to IDLE; all counters clear;
  - every output is 0, including inst_in and din_overlay.
  - Reset mid-job aborts immediately; no done pulse.
- States: IDLE, INST, DATA, COMP, DRAIN, DONE.
- IDLE:
  - on start=1, latch cfg_inst_num;
  - next state is INST, or DATA if cfg_inst_num==0.
  - start outside IDLE is ignored.
- INST:
  - s_inst_rdy=1.
  - Each handshake registers s_inst into inst_in with inst_in_v=1 the following cycle (1-cycle latency); inst_in_v=0 on cycles without a handshake.
  - After the cfg_inst_num-th handshake, go to DATA.
- DATA:
  - s_data_rdy=1.
  - Each handshake produces din_overlay/din_overlay_v one cycle later.
  - After PE_NUM handshakes, go to COMP.
  - Host gaps (s_data_v=0) are allowed; the counter holds.
- COMP:
  - alpha_v=1 on the first COMP cycle only.
  - Counter runs COMPUTE_LAT cycles, then go to DRAIN with load=1 on the first DRAIN cycle only.
- DRAIN:
  - Count dout_overlay_v cycles.
  - After the PE_NUM-th, go to DONE.
  - dout_overlay_v while not in DRAIN is ignored.
- DONE: done=1 for one cycle, then IDLE.
- Ready signals:
  - s_inst_rdy=1 only in INST; s_data_rdy=1 only in DATA.
  - Host valid in any other state is not accepted.
- ce=1 in all non-IDLE states, and on the cycle after the last DATA handshake so the registered word reaches the overlay.
- Counters are sized $clog2(max+1) and never wrap: each compares to its limit and clears on state exit.
- A handshake on the same cycle as a state exit is counted; it is the final item.

Optional Feature:
- Macro: OVERLAY_CTRL_WATCHDOG_EN.
- With the macro:
  - a DRAIN cycle counter resets on entry and on each dout_overlay_v;
  - if it reaches TIMEOUT, go to DONE, pulse done, and set err=1;
  - err is sticky until the next accepted start or reset.
- Without the macro: err is constant 0 and DRAIN waits indefinitely.

Test Plan:
- Reset and idle: hold rst=0 for 3 cycles, release -> all outputs 0, busy=0; s_data_v=1 gives s_data_rdy=0.
- Normal job: cfg_inst_num=3 and start; 3 instructions A,B,C with valid held; 8 data words 1..8 -> all of the following:
  - inst_in_v 3 cycles carrying A,B,C;
  - din_overlay_v 8 cycles carrying 1..8;
  - alpha_v a single pulse;
  - load pulses exactly 12 cycles after alpha_v;
  - after 8 dout_overlay_v, done pulses once and busy drops.
- Zero instructions: cfg_inst_num=0 -> no inst_in_v; s_data_rdy=1 on the cycle after start.
- Host gaps: data valid toggled 1,0,1,0… -> exactly 8 din_overlay_v pulses; alpha_v only after the 8th.
- Abort: rst=0 during DRAIN after 4 outputs -> next cycle all outputs 0, state IDLE, no done; a new start runs a full job cleanly.
- Watchdog (macro on, TIMEOUT=20): only 5 dout_overlay_v in DRAIN -> done and err=1 20 cycles after the last one; err clears on the next start.
